// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int prod_width(input int width);
      return 2 * width;
   endfunction

endpackage

// File: rtl/multiplier_4x4.sv
// Unsigned shift-add multiplier, one partial product per clock.
// Operands are latched on start; P holds the last completed result.
//
// state | meaning
// IDLE  | waiting for start, done low
// RUN   | accumulating partial products, busy high
module multiplier_4x4
   import mult_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [WIDTH-1:0]             A,
   input  logic [WIDTH-1:0]             B,
   output logic                         busy,
   output logic                         done,
   output logic [prod_width(WIDTH)-1:0] P
);

   localparam int PW = prod_width(WIDTH);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t          r_state;
   state_t          w_state_next;
   logic [PW-1:0]   r_a;
   logic [WIDTH-1:0] r_b;
   logic [PW-1:0]   r_acc;
   logic [CW-1:0]   r_cnt;
   logic [PW-1:0]   r_p;
   logic            r_busy;
   logic            r_done;
   logic            w_accept;
   logic            w_last;
   logic [PW-1:0]   w_acc_next;

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      w_acc_next   = r_acc + (r_b[0] ? r_a : '0);
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = RUN;
            end
         end
         RUN: begin
            if (r_cnt == CNT_LAST) begin
               w_last       = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= '0;
         r_cnt  <= '0;
         r_p    <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_a    <= PW'(A);
            r_b    <= B;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
         end else if (r_state == RUN) begin
            r_acc <= w_acc_next;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
            // last iteration: publish the sum including this cycle's partial product
            if (w_last) begin
               r_p    <= w_acc_next;
               r_done <= 1'b1;
               r_busy <= 1'b0;
               r_cnt  <= '0;
            end
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign P    = r_p;

endmodule

// File: tb/tb_multiplier_4x4.sv
// Directed and sweep checks for the 4x4 sequential multiplier.
module tb_multiplier_4x4;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] A;
   logic [3:0] B;
   logic       busy;
   logic       done;
   logic [7:0] P;

   int total = 0;
   int bad   = 0;

   multiplier_4x4 #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .P     (P)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // accept one operation and wait for done; latency counted in edges after accept
   task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                         output logic [7:0] p, output int lat, output logic timed_out);
      logic got;
      start = 1'b1;
      A = a;
      B = b;
      tick();
      start = 1'b0;
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         tick();
         lat++;
         if (done) got = 1'b1;
      end
      timed_out = !got;
      p = P;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      A = '0;
      B = '0;
      tick();
      tick();
      total++;
      if (P !== 8'd0) begin bad++; $display("FAIL reset_p got=%0d exp=0", P); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_zero();
      logic [7:0] p;
      int lat;
      logic to;
      run_op(4'd0, 4'd0, p, lat, to);
      total++;
      if (to || lat != 4) begin bad++; $display("FAIL zero_latency got=%0d exp=4 timeout=%b", lat, to); end
      total++;
      if (p !== 8'd0) begin bad++; $display("FAIL zero_p got=%0d exp=0", p); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b exp=0", busy); end
      tick();
   endtask

   task automatic test_basic();
      logic [3:0] va [4] = '{4'd2, 4'd13, 4'd10, 4'd15};
      logic [3:0] vb [4] = '{4'd3, 4'd4,  4'd10, 4'd15};
      logic [7:0] ve [4] = '{8'd6, 8'd52, 8'd100, 8'd225};
      logic [7:0] p;
      int lat;
      logic to;
      for (int k = 0; k < 4; k++) begin
         run_op(va[k], vb[k], p, lat, to);
         total++;
         if (p !== ve[k]) begin bad++; $display("FAIL basic_p%0d got=%0d exp=%0d", k, p, ve[k]); end
         total++;
         if (to || lat != 4) begin bad++; $display("FAIL basic_lat%0d got=%0d exp=4", k, lat); end
         tick();
         total++;
         if (done !== 1'b0) begin bad++; $display("FAIL basic_single_pulse%0d got=%b exp=0", k, done); end
      end
   endtask

   task automatic test_busy_ignore();
      int lat;
      logic got;
      start = 1'b1;
      A = 4'd2;
      B = 4'd3;
      tick();
      A = 4'd15;
      B = 4'd15;
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         tick();
         lat++;
         if (done) got = 1'b1;
      end
      total++;
      if (!got || lat != 4 || P !== 8'd6) begin
         bad++; $display("FAIL busy_ignore_first got=%0d lat=%0d exp=6 lat=4", P, lat);
      end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL busy_ignore_idle got=%b exp=0", busy); end
      tick();
      start = 1'b0;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL busy_ignore_accept got=%b exp=1", busy); end
      total++;
      if (P !== 8'd6) begin bad++; $display("FAIL busy_ignore_hold got=%0d exp=6", P); end
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         tick();
         lat++;
         if (done) got = 1'b1;
      end
      total++;
      if (!got || lat != 4 || P !== 8'd225) begin
         bad++; $display("FAIL busy_ignore_second got=%0d lat=%0d exp=225 lat=4", P, lat);
      end
      tick();
   endtask

   task automatic test_reset_abort();
      logic [7:0] p;
      int lat;
      logic to;
      logic seen;
      start = 1'b1;
      A = 4'd13;
      B = 4'd4;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      total++;
      if (P !== 8'd0) begin bad++; $display("FAIL abort_p got=%0d exp=0", P); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
      seen = done;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b exp=0", seen); end
      run_op(4'd10, 4'd10, p, lat, to);
      total++;
      if (to || p !== 8'd100) begin bad++; $display("FAIL abort_recover got=%0d exp=100", p); end
      tick();
   endtask

   task automatic test_sweep();
      int off;
      int idx;
      int exp_p;
      logic [7:0] prev_p;
      logic stable;
      logic got;
      int lat;
      off = int'($urandom_range(0, 255));
      prev_p = P;
      for (int k = 0; k < 256; k++) begin
         idx = (k * 37 + off) % 256;
         exp_p = (idx / 16) * (idx % 16);
         start = 1'b1;
         A = 4'(idx / 16);
         B = 4'(idx % 16);
         tick();
         start = 1'b0;
         stable = 1'b1;
         got = 1'b0;
         lat = 0;
         for (int i = 0; i < 12 && !got; i++) begin
            if (P !== prev_p) stable = 1'b0;
            A = 4'($urandom_range(0, 15));
            B = 4'($urandom_range(0, 15));
            tick();
            lat++;
            if (done) got = 1'b1;
         end
         total++;
         if (!got || lat != 4 || P !== 8'(exp_p)) begin
            bad++;
            $display("FAIL sweep_p a=%0d b=%0d got=%0d exp=%0d lat=%0d", idx / 16, idx % 16, P, exp_p, lat);
         end
         total++;
         if (!stable) begin bad++; $display("FAIL sweep_stable a=%0d b=%0d p_changed_exp=%0d", idx / 16, idx % 16, prev_p); end
         prev_p = P;
      end
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      A = '0;
      B = '0;
      test_reset();
      test_zero();
      test_basic();
      test_busy_ignore();
      test_reset_abort();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
